// File: rtl/dmem_bus_if.sv
// rtl/dmem_bus_if.sv - CPU, DMA and slave signals around the data-memory bus arbiter
interface dmem_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_wr;
    logic          dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic          s_rd;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic          s_ready;

    logic [1:0]    grant;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output s_rd, s_wr, s_addr, s_wdata,
        input  s_rdata, s_ready,
        output grant
    );

    // Requesters and memory/peripheral side
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  s_rd, s_wr, s_addr, s_wdata,
        output s_rdata, s_ready,
        input  grant
    );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - CPU/DMA arbiter for the shared data-memory bus
// Zero-latency grant, ownership held across wait states, bounded starvation both ways.
module dmem_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int MAX_LOCK   = 16
) (
    input logic       clk,
    input logic       reset,
    dmem_bus_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA, LOCK_DMA} state_e;

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(MAX_LOCK);

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          cpu_prio_q, cpu_prio_d;

    logic          sel_cpu, sel_dma;
    logic          cpu_ack, dma_ack;
    logic [LW-1:0] lock_beats;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    // Current-cycle owner; a dropped request leaves the bus without an owner.
    always_comb begin
        sel_cpu = 1'b0;
        sel_dma = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (cpu_prio_q && bus.cpu_req)
                        sel_cpu = 1'b1;
                    else if (bus.dma_req && (streak_q == STREAK_MAX || !bus.cpu_req))
                        sel_dma = 1'b1;
                    else
                        sel_cpu = bus.cpu_req;
                end
                BUSY_CPU:           sel_cpu = bus.cpu_req;
                BUSY_DMA, LOCK_DMA: sel_dma = bus.dma_req;
                default: ;
            endcase
        end
    end

    assign cpu_ack = sel_cpu & bus.s_ready;
    assign dma_ack = sel_dma & bus.s_ready;

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (sel_cpu) begin
            addr_mux  = bus.cpu_addr;
            wdata_mux = bus.cpu_wdata;
        end else if (sel_dma) begin
            addr_mux  = bus.dma_addr;
            wdata_mux = bus.dma_wdata;
        end
    end

    assign bus.s_addr    = addr_mux;
    assign bus.s_wdata   = wdata_mux;
    assign bus.s_rd      = (sel_cpu & ~bus.cpu_wr) | (sel_dma & ~bus.dma_wr);
    assign bus.s_wr      = (sel_cpu &  bus.cpu_wr) | (sel_dma &  bus.dma_wr);
    assign bus.cpu_ack   = cpu_ack;
    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
    assign bus.cpu_rdata = bus.s_rdata;
    assign bus.dma_rdata = bus.s_rdata;
    assign bus.grant     = {sel_dma, sel_cpu};

    assign lock_beats = (dma_ack && lock_cnt_q != LOCK_MAX) ? lock_cnt_q + LW'(1) : lock_cnt_q;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        lock_cnt_d = lock_cnt_q;
        cpu_prio_d = cpu_prio_q;

        if (!bus.dma_req || dma_ack)
            streak_d = '0;
        else if (cpu_ack && streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);

        case (state_q)
            IDLE, BUSY_CPU, BUSY_DMA: begin
                if (state_q == IDLE)
                    cpu_prio_d = 1'b0;
                if (dma_ack && bus.dma_lock) begin
                    state_d    = LOCK_DMA;
                    lock_cnt_d = LW'(1);
                end else if (sel_cpu && !bus.s_ready) begin
                    state_d = BUSY_CPU;
                end else if (sel_dma && !bus.s_ready) begin
                    state_d = BUSY_DMA;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK_DMA: begin
                lock_cnt_d = lock_beats;
                if ((dma_ack && !bus.dma_lock) || (!bus.dma_req && !bus.dma_lock)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (bus.cpu_req && lock_beats == LOCK_MAX &&
                             !(bus.dma_req && !bus.s_ready)) begin
                    // Never cut a beat in its wait states; release between beats only.
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                    cpu_prio_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            lock_cnt_q <= '0;
            cpu_prio_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            lock_cnt_q <= lock_cnt_d;
            cpu_prio_q <= cpu_prio_d;
        end
    end
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - self-checking bench for dmem_bus_arbiter
module tb_dmem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_STREAK = 4;
    localparam int MAX_LOCK = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_bus_if #(.AW(AW), .DW(DW)) bus ();

    dmem_bus_arbiter #(
        .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: who holds the bus (0 free, 1 CPU, 2 DMA), whether DMA holds a lock,
    // beats in that lock, consecutive CPU wins while DMA waits, and the CPU-first token.
    int m_hold, m_beats, m_streak;
    bit m_locked, m_cpu_first;
    bit m_cpu_ack, m_dma_ack;

    logic [31:0] q_ack[$], q_grant[$], q_stall[$], q_srd[$], q_swr[$], q_addr[$], q_wdata[$];
    logic [31:0] last_dma_rdata;

    task automatic clear_obs();
        q_ack.delete(); q_grant.delete(); q_stall.delete(); q_srd.delete();
        q_swr.delete(); q_addr.delete(); q_wdata.delete();
    endtask

    task automatic step();
        int who;
        bit done;
        logic [1:0] e_grant;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        if (reset) begin
            who = 0; m_hold = 0; m_locked = 0; m_beats = 0; m_streak = 0; m_cpu_first = 0;
        end else if (m_hold == 1) who = bus.cpu_req ? 1 : 0;
        else if (m_hold == 2 || m_locked) who = bus.dma_req ? 2 : 0;
        else if (m_cpu_first && bus.cpu_req) who = 1;
        else if (bus.dma_req && (m_streak == MAX_STREAK || !bus.cpu_req)) who = 2;
        else if (bus.cpu_req) who = 1;
        else who = 0;
        done = (who != 0) && bus.s_ready;
        m_cpu_ack = (who == 1) && done;
        m_dma_ack = (who == 2) && done;
        e_grant = (who == 1) ? 2'b01 : (who == 2) ? 2'b10 : 2'b00;
        e_addr  = (who == 1) ? bus.cpu_addr  : (who == 2) ? bus.dma_addr  : 32'h0;
        e_wdata = (who == 1) ? bus.cpu_wdata : (who == 2) ? bus.dma_wdata : 32'h0;

        check_eq("grant", 32'(bus.grant), 32'(e_grant));
        check_eq("cpu_ack", 32'(bus.cpu_ack), 32'(m_cpu_ack));
        check_eq("dma_ack", 32'(bus.dma_ack), 32'(m_dma_ack));
        check_eq("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !m_cpu_ack));
        check_eq("s_rd", 32'(bus.s_rd), 32'((who == 1 && !bus.cpu_wr) || (who == 2 && !bus.dma_wr)));
        check_eq("s_wr", 32'(bus.s_wr), 32'((who == 1 && bus.cpu_wr) || (who == 2 && bus.dma_wr)));
        check_eq("s_addr", bus.s_addr, e_addr);
        check_eq("s_wdata", bus.s_wdata, e_wdata);
        if (m_cpu_ack) check_eq("cpu_rdata", bus.cpu_rdata, bus.s_rdata);
        if (m_dma_ack) check_eq("dma_rdata", bus.dma_rdata, bus.s_rdata);

        q_ack.push_back({30'd0, bus.dma_ack, bus.cpu_ack});
        q_grant.push_back(32'(bus.grant));
        q_stall.push_back(32'(bus.cpu_stall));
        q_srd.push_back(32'(bus.s_rd));
        q_swr.push_back(32'(bus.s_wr));
        q_addr.push_back(bus.s_addr);
        q_wdata.push_back(bus.s_wdata);
        if (bus.dma_ack) last_dma_rdata = bus.dma_rdata;

        if (!reset) begin
            if (!bus.dma_req || m_dma_ack) m_streak = 0;
            else if (m_cpu_ack && m_streak < MAX_STREAK) m_streak++;
            if (m_locked) begin
                if (m_dma_ack && m_beats < MAX_LOCK) m_beats++;
                if ((m_dma_ack && !bus.dma_lock) || (!bus.dma_req && !bus.dma_lock)) begin
                    m_locked = 0; m_beats = 0;
                end else if (bus.cpu_req && m_beats == MAX_LOCK && !(bus.dma_req && !bus.s_ready)) begin
                    m_locked = 0; m_beats = 0; m_cpu_first = 1;
                end
            end else begin
                if (m_hold == 0) m_cpu_first = 0;
                if (m_dma_ack && bus.dma_lock) begin
                    m_locked = 1; m_beats = 1; m_hold = 0;
                end else begin
                    m_hold = (who != 0 && !done) ? who : 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0; bus.s_ready = 1'b1;
        step(); step();
    endtask

    int beats;

    initial begin
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_wr = 0; bus.dma_lock = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        bus.s_rdata = 0; bus.s_ready = 0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset in the middle of a waited DMA write
        clear_obs();
        bus.dma_req = 1; bus.dma_wr = 1; bus.dma_addr = 32'h80; bus.dma_wdata = 32'hA5A5A5A5;
        bus.s_ready = 0;
        step(); step();
        reset = 1'b1;
        step();
        check_eq("rst_grant", q_grant[2], 32'd0);
        check_eq("rst_s_wr", q_swr[2], 32'd0);
        check_eq("rst_no_ack", q_ack[2], 32'd0);
        reset = 1'b0; bus.dma_req = 0;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h44; bus.s_ready = 1;
        step();
        check_eq("post_rst_cpu_ack", q_ack[3], 32'd1);
        idle_bus();

        // Both requesting continuously: four CPU wins then one DMA slot
        clear_obs();
        bus.cpu_req = 1; bus.dma_req = 1; bus.dma_lock = 0; bus.dma_wr = 0; bus.s_ready = 1;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 10; i++) begin
            check_eq("streak_ack", q_ack[i], (i % 5 == 4) ? 32'd2 : 32'd1);
            check_eq("streak_stall", q_stall[i], (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        idle_bus();

        // DMA read with three wait states, CPU arrives meanwhile
        clear_obs();
        bus.dma_req = 1; bus.dma_wr = 0; bus.dma_addr = 32'h10; bus.s_ready = 0; bus.s_rdata = 0;
        step();
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h100;
        step(); step();
        bus.s_ready = 1; bus.s_rdata = 32'hDEADBEEF;
        step();
        bus.dma_req = 0;
        step();
        for (int i = 0; i < 4; i++) check_eq("wait_grant", q_grant[i], 32'd2);
        for (int i = 0; i < 3; i++) check_eq("wait_no_ack", q_ack[i], 32'd0);
        check_eq("wait_dma_ack", q_ack[3], 32'd2);
        check_eq("wait_rdata", last_dma_rdata, 32'hDEADBEEF);
        check_eq("wait_cpu_after", q_ack[4], 32'd1);
        idle_bus();

        // 20-beat locked DMA burst with the CPU waiting from beat 2
        clear_obs();
        bus.dma_req = 1; bus.dma_wr = 1; bus.dma_lock = 1; bus.dma_addr = 32'h1000; bus.s_ready = 1;
        bus.cpu_wr = 0; bus.cpu_addr = 32'h300;
        beats = 0;
        for (int c = 0; c < 60 && beats < 20; c++) begin
            step();
            if (m_cpu_ack) bus.cpu_req = 0;
            if (m_dma_ack) begin
                beats++;
                bus.dma_addr = bus.dma_addr + 32'd4;
                bus.dma_wdata = $urandom;
                bus.dma_lock = (beats < 19);
                if (beats == 20) bus.dma_req = 0;
            end
            if (c == 0) bus.cpu_req = 1;
        end
        check_eq("burst_beats", 32'(beats), 32'd20);
        check_eq("burst_len", 32'(q_ack.size()), 32'd21);
        if (q_ack.size() == 21) begin
            for (int i = 0; i < 21; i++)
                check_eq("burst_ack", q_ack[i], (i == 16) ? 32'd1 : 32'd2);
            for (int i = 1; i < 16; i++) check_eq("burst_stall", q_stall[i], 32'd1);
            check_eq("burst_stall_ack", q_stall[16], 32'd0);
        end
        idle_bus();

        // CPU write with two wait states
        clear_obs();
        bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 32'h40000000; bus.cpu_wdata = 32'h12345678;
        bus.s_ready = 0;
        step(); step();
        bus.s_ready = 1;
        step();
        bus.cpu_req = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("wr_s_wr", q_swr[i], 32'd1);
            check_eq("wr_addr", q_addr[i], 32'h40000000);
            check_eq("wr_data", q_wdata[i], 32'h12345678);
            check_eq("wr_ack", q_ack[i], (i == 2) ? 32'd1 : 32'd0);
        end
        check_eq("wr_s_wr_after", q_swr[3], 32'd0);
        idle_bus();

        // DMA abandons a waited read; pending CPU goes next
        clear_obs();
        bus.dma_req = 1; bus.dma_wr = 0; bus.dma_addr = 32'h20; bus.s_ready = 0;
        step();
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h200;
        step();
        bus.dma_req = 0; bus.s_ready = 1;
        step(); step();
        check_eq("abort_srd_before", q_srd[1], 32'd1);
        check_eq("abort_srd", q_srd[2], 32'd0);
        check_eq("abort_no_ack", q_ack[2], 32'd0);
        check_eq("abort_grant", q_grant[2], 32'd0);
        check_eq("abort_cpu_ack", q_ack[3], 32'd1);
        idle_bus();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) reset = 1'b1;
            step();
            reset = 1'b0;
            if (m_cpu_ack || !bus.cpu_req) begin
                bus.cpu_req = 1'($urandom_range(0, 1));
                bus.cpu_wr = 1'($urandom_range(0, 1));
                bus.cpu_addr = $urandom;
                bus.cpu_wdata = $urandom;
            end else if ($urandom_range(0, 31) == 0) bus.cpu_req = 0;
            if (m_dma_ack || !bus.dma_req) begin
                bus.dma_req = ($urandom_range(0, 2) != 0);
                bus.dma_wr = 1'($urandom_range(0, 1));
                bus.dma_lock = ($urandom_range(0, 3) != 0);
                bus.dma_addr = $urandom;
                bus.dma_wdata = $urandom;
            end else if ($urandom_range(0, 31) == 0) bus.dma_req = 0;
            bus.s_ready = ($urandom_range(0, 3) != 0);
            bus.s_rdata = $urandom;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory/peripheral bus between two requesters: the pipeline MEM stage (CPU) and a UART boot-loader/DMA engine (DMA).
- Sits between the MEM-stage load/store signals and the DataMem/Peripheral decode.
- Grants zero-latency access to the CPU when the bus is free. Holds ownership across slave wait states and supports locked DMA bursts.
- Bounds starvation in both directions and drives the CPU stall for the hazard unit.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STREAK, 4, consecutive CPU acks while DMA waits before DMA is forced a slot (>=1)
MAX_LOCK, 16, max consecutive locked DMA beats before a forced CPU slot (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_wr  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data, valid only while cpu_ack=1
cpu_ack  out  1  one-cycle completion strobe
cpu_stall  out  1  cpu_req & ~cpu_ack, to hazard unit (freezes PC/IF/ID/EX/MEM)
dma_req  in  1  DMA request, held until dma_ack
dma_wr  in  1  1=write, 0=read
dma_lock  in  1  keep bus after this beat
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_rdata  out  DW  read data, valid only while dma_ack=1
dma_ack  out  1  one-cycle completion strobe
s_rd  out  1  slave read strobe
s_wr  out  1  slave write strobe
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_rdata  in  DW  slave read data
s_ready  in  1  slave completes current access this cycle
grant  out  2  00 none, 01 CPU, 10 DMA (current-cycle owner)

Behaviour:
- Reset: state IDLE; streak=0; lock_cnt=0; acks, s_rd, s_wr=0; grant=00; s_addr and s_wdata=0 while no owner. A reset during an access abandons it with no ack.
- States: IDLE, BUSY_CPU, BUSY_DMA, LOCK_DMA.
- IDLE, combinational winner:
  - DMA if dma_req and (streak==MAX_STREAK or ~cpu_req).
  - Otherwise CPU if cpu_req.
  - Otherwise none.
- The owner drives s_addr, s_wdata, s_rd=req&~wr and s_wr=req&wr in the same cycle.
- If s_ready=1: ack the owner this cycle (single-cycle slave = zero added latency). Next state is LOCK_DMA if the owner is DMA and dma_lock=1, else IDLE.
- If s_ready=0: go to BUSY_owner.
- BUSY_x: ownership frozen, no preemption. The slave stays driven from x; ack x on the first s_ready=1, then take the same next-state rule as IDLE.
- Dropping req before ack aborts the access: s_rd/s_wr go low that cycle, no ack, IDLE next cycle.
- LOCK_DMA: DMA owns the bus and the CPU stalls.
  - Each acked beat increments lock_cnt.
  - Exit to IDLE when an acked beat has dma_lock=0, or when dma_req=0 and dma_lock=0.
  - Forced release: when lock_cnt reaches MAX_LOCK and cpu_req=1, go to IDLE with a CPU-priority flag so the next IDLE grant goes to the CPU even if streak==MAX_STREAK.
  - lock_cnt clears on leaving LOCK_DMA.
- streak:
  - +1 on each cpu_ack with dma_req=1, saturating at MAX_STREAK.
  - Cleared on any dma_ack or any cycle with dma_req=0.
- cpu_rdata=dma_rdata=s_rdata (pass-through). Requesters sample only on ack.
- No more than one of cpu_ack/dma_ack is ever high in a cycle. An ack never occurs without the matching req.
- Writes reach the slave exactly once per ack, with no duplicate strobe across BUSY cycles beyond what s_ready demands.

Test Plan:
- Reset asserted mid-BUSY_DMA, s_ready=0 -> next edge grant=00, s_wr=0, no dma_ack. After release, cpu_req with s_ready=1 -> cpu_ack the same cycle.
- cpu_req and dma_req both constant high, s_ready=1 -> ack pattern CPU,CPU,CPU,CPU,DMA repeating (MAX_STREAK=4). cpu_stall=1 exactly on the DMA cycles.
- DMA read of 0x00000010 with s_ready low for 3 cycles, cpu_req rising in cycle 2 -> grant=10 held 4 cycles, dma_ack on cycle 4 with dma_rdata=s_rdata (0xDEADBEEF). CPU acked on cycle 5.
- Locked DMA burst of 20 beats, cpu_req high from beat 1, s_ready=1 -> 16 dma_acks, then 1 cpu_ack, then remaining beats. cpu_stall high throughout except the cpu_ack cycle.
- CPU write 0x40000000/0x12345678 with s_ready=0 for 2 cycles -> s_wr high 3 cycles, s_addr/s_wdata stable, single cpu_ack on cycle 3.
- DMA drops dma_req in BUSY_DMA -> s_rd low that cycle, no dma_ack, IDLE next cycle, pending cpu_req acked.
